// File: rtl/parking_lot_monitor.sv
// Parking lot occupancy monitor.
// Each gate has a pair of beam sensors. A per-gate FSM decodes the order
// in which the beams break into entry and exit events. A shared
// saturating counter tracks occupancy, and an optional seven-segment
// display shows the count.
// Define PARKING_LOT_MONITOR_HEX_EN to compile in the HEX0..HEX5 decode.
// Without it the displays are held dark.

// Per-gate lane: sensor synchronizers, direction FSM, event pulse pipeline.
module parking_lot_gate (
    input  logic clk,
    input  logic reset,
    input  logic outer,
    input  logic inner,
    output logic enter,
    output logic exit
);
    typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT} state_t;

    state_t     state, state_nx;
    logic [1:0] outer_sync, inner_sync;
    logic [1:0] s;
    logic       fire_enter, fire_exit;
    logic       enter_q, exit_q;

    // two-flop synchronizers on the raw, asynchronous sensor inputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            outer_sync <= '0;
            inner_sync <= '0;
        end else begin
            outer_sync <= {outer_sync[0], outer};
            inner_sync <= {inner_sync[0], inner};
        end
    end

    assign s = {outer_sync[1], inner_sync[1]};

    // state register; the completion event is captured alongside the return to IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            enter_q <= fire_enter;
            exit_q  <= fire_exit;
        end
    end

    // next-state decode; backtracking one step is legal, and any illegal pattern parks in WAIT
    always_comb begin
        state_nx   = state;
        fire_enter = 1'b0;
        fire_exit  = 1'b0;
        case (state)
            IDLE: case (s)
                2'b10:   state_nx = IN1;
                2'b01:   state_nx = OUT1;
                2'b11:   state_nx = WAIT;
                default: state_nx = IDLE;
            endcase
            IN1: case (s)
                2'b11:   state_nx = IN2;
                2'b00:   state_nx = IDLE;
                2'b01:   state_nx = WAIT;
                default: state_nx = IN1;
            endcase
            IN2: case (s)
                2'b01:   state_nx = IN3;
                2'b10:   state_nx = IN1;
                2'b00:   state_nx = IDLE;
                default: state_nx = IN2;
            endcase
            IN3: case (s)
                2'b00: begin
                    state_nx   = IDLE;
                    fire_enter = 1'b1;
                end
                2'b11:   state_nx = IN2;
                2'b10:   state_nx = WAIT;
                default: state_nx = IN3;
            endcase
            OUT1: case (s)
                2'b11:   state_nx = OUT2;
                2'b00:   state_nx = IDLE;
                2'b10:   state_nx = WAIT;
                default: state_nx = OUT1;
            endcase
            OUT2: case (s)
                2'b10:   state_nx = OUT3;
                2'b01:   state_nx = OUT1;
                2'b00:   state_nx = IDLE;
                default: state_nx = OUT2;
            endcase
            OUT3: case (s)
                2'b00: begin
                    state_nx  = IDLE;
                    fire_exit = 1'b1;
                end
                2'b11:   state_nx = OUT2;
                2'b01:   state_nx = WAIT;
                default: state_nx = OUT3;
            endcase
            WAIT:    state_nx = (s == 2'b00) ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // output pulse register
    always_ff @(posedge clk) begin
        if (!reset) begin
            enter <= 1'b0;
            exit  <= 1'b0;
        end else begin
            enter <= enter_q;
            exit  <= exit_q;
        end
    end
endmodule

module parking_lot_monitor #(
    parameter int NUM_GATES = 2,
    parameter int CAPACITY  = 16,
    parameter int CNT_W     = $clog2(CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] outer,
    input  logic [NUM_GATES-1:0] inner,
    output logic [NUM_GATES-1:0] enter,
    output logic [NUM_GATES-1:0] exit,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 reject,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [6:0]           HEX4,
    output logic [6:0]           HEX5
);
    // sign bit plus headroom for +NUM_GATES above CAPACITY
    localparam int SW = CNT_W + 4;

    parking_lot_gate u_gate [NUM_GATES-1:0] (
        .clk   (clk),
        .reset (reset),
        .outer (outer),
        .inner (inner),
        .enter (enter),
        .exit  (exit)
    );

    logic [2:0]           n_ent, n_ext;
    logic signed [SW-1:0] sum;
    logic [CNT_W-1:0]     cnt_nx;
    logic                 rej_nx;

    // popcount of this cycle's entry and exit pulses
    always_comb begin
        n_ent = '0;
        n_ext = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            n_ent = n_ent + 3'(enter[g]);
            n_ext = n_ext + 3'(exit[g]);
        end
    end

    assign sum = $signed({4'b0, count}) + $signed({{(SW-3){1'b0}}, n_ent})
               - $signed({{(SW-3){1'b0}}, n_ext});

    // apply the net delta once; clamp into [0, CAPACITY], and flag overflow as a reject
    always_comb begin
        cnt_nx = count;
        rej_nx = 1'b0;
        if (sum[SW-1]) begin
            cnt_nx = '0;
        end else if (sum > $signed(SW'(CAPACITY))) begin
            cnt_nx = CNT_W'(CAPACITY);
            rej_nx = 1'b1;
        end else begin
            cnt_nx = sum[CNT_W-1:0];
        end
    end

    // occupancy register; the flags are derived from the same next value, so they stay consistent
    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            reject <= 1'b0;
        end else begin
            count  <= cnt_nx;
            full   <= (cnt_nx == CNT_W'(CAPACITY));
            empty  <= (cnt_nx == '0);
            reject <= rej_nx;
        end
    end

`ifdef PARKING_LOT_MONITOR_HEX_EN
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_U     = 7'b1000001;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    logic [3:0] tens, ones;

    // display decode from the registered count and flags
    always_comb begin
        tens = 4'(count / 10);
        ones = 4'(count % 10);
        HEX0 = seg7(ones);
        HEX1 = (tens == 4'd0) ? SEG_BLANK : seg7(tens);
        HEX2 = SEG_BLANK;
        HEX3 = SEG_BLANK;
        HEX4 = SEG_BLANK;
        HEX5 = SEG_BLANK;
        if (empty) begin
            HEX5 = SEG_C;
            HEX4 = SEG_L;
            HEX3 = SEG_E;
            HEX2 = SEG_A;
            HEX1 = SEG_R;
            HEX0 = seg7(4'd0);
        end else if (full) begin
            HEX5 = SEG_F;
            HEX4 = SEG_U;
            HEX3 = SEG_L;
            HEX2 = SEG_L;
        end
    end
`else
    assign HEX0 = 7'b1111111;
    assign HEX1 = 7'b1111111;
    assign HEX2 = 7'b1111111;
    assign HEX3 = 7'b1111111;
    assign HEX4 = 7'b1111111;
    assign HEX5 = 7'b1111111;
`endif
endmodule

// File: tb/tb_parking_lot_monitor.sv
// Scoreboard bench for parking_lot_monitor. Each driven gate sequence pushes
// its expected pulse pattern and the resulting count state. A per-cycle
// monitor pops the scoreboard on each pulse and checks the count update
// one cycle later.
module tb_parking_lot_monitor;
    localparam int NG  = 2;
    localparam int CAP = 16;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [NG-1:0] outer, inner, enter, exit;
    logic [CW-1:0] count;
    logic          full, empty, reject;
    logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5;

    always #5 clk = ~clk;

    parking_lot_monitor #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
        .clk(clk), .reset(reset), .outer(outer), .inner(inner),
        .enter(enter), .exit(exit), .count(count), .full(full),
        .empty(empty), .reject(reject),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
    );

    typedef struct {
        logic [NG-1:0] en;
        logic [NG-1:0] ex;
        int            cnt;
        logic          fl;
        logic          em;
        logic          rj;
    } exp_t;

    exp_t sb[$];
    exp_t pend_exp;
    bit   pend;
    int   model_count;
    int   n_chk, n_fail;

    function automatic logic [6:0] dig(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; 9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // expected {HEX5..HEX0} for a given occupancy
    function automatic logic [41:0] exp_hex(input int c);
`ifdef PARKING_LOT_MONITOR_HEX_EN
        logic [6:0] t;
        t = (c / 10 == 0) ? 7'h7F : dig(c / 10);
        if (c == 0)   return {7'h46, 7'h47, 7'h06, 7'h08, 7'h2F, 7'h40};
        if (c == CAP) return {7'h0E, 7'h41, 7'h47, 7'h47, t, dig(c % 10)};
        return {7'h7F, 7'h7F, 7'h7F, 7'h7F, t, dig(c % 10)};
`else
        return {42{1'b1}} | 42'(c & 0);
`endif
    endfunction

    task automatic push_exp(input logic [NG-1:0] e, input logic [NG-1:0] x);
        exp_t it;
        int   t;
        t = model_count + $countones(e) - $countones(x);
        it.rj = (t > CAP);
        if (t > CAP) t = CAP;
        if (t < 0) t = 0;
        model_count = t;
        it.en = e; it.ex = x; it.cnt = t;
        it.fl = (t == CAP); it.em = (t == 0);
        sb.push_back(it);
    endtask

    // one clock: wait for the falling edge, then run the scoreboard monitor
    task automatic step();
        exp_t cur;
        @(negedge clk);
        if (pend) begin
            n_chk++;
            if (count !== CW'(pend_exp.cnt) || full !== pend_exp.fl || empty !== pend_exp.em || reject !== pend_exp.rj) begin
                n_fail++;
                $display("FAIL count_update: got count=%0d full=%b empty=%b reject=%b, want count=%0d full=%b empty=%b reject=%b",
                         count, full, empty, reject, pend_exp.cnt, pend_exp.fl, pend_exp.em, pend_exp.rj);
            end
            n_chk++;
            if ({hex5, hex4, hex3, hex2, hex1, hex0} !== exp_hex(pend_exp.cnt)) begin
                n_fail++;
                $display("FAIL hex_update: got %h want %h", {hex5, hex4, hex3, hex2, hex1, hex0}, exp_hex(pend_exp.cnt));
            end
            pend = 0;
        end else begin
            n_chk++;
            if (reject !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_idle: got %b want 0", reject);
            end
        end
        if ((enter | exit) !== '0) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_pulse: got enter=%b exit=%b want none", enter, exit);
            end else begin
                cur = sb.pop_front();
                n_chk++;
                if (enter !== cur.en || exit !== cur.ex) begin
                    n_fail++;
                    $display("FAIL pulse: got enter=%b exit=%b want enter=%b exit=%b", enter, exit, cur.en, cur.ex);
                end
                pend_exp = cur;
                pend = 1;
            end
        end
    endtask

    // walk entering gates through 10,11,01,00 and exiting gates through 01,11,10,00 in lockstep
    task automatic gate_seq(input logic [NG-1:0] em, input logic [NG-1:0] xm, input int hold);
        logic [1:0] pe, px;
        push_exp(em, xm);
        for (int p = 0; p < 4; p++) begin
            case (p)
                0:       begin pe = 2'b10; px = 2'b01; end
                1:       begin pe = 2'b11; px = 2'b11; end
                2:       begin pe = 2'b01; px = 2'b10; end
                default: begin pe = 2'b00; px = 2'b00; end
            endcase
            for (int g = 0; g < NG; g++) begin
                if (em[g])      {outer[g], inner[g]} = pe;
                else if (xm[g]) {outer[g], inner[g]} = px;
            end
            repeat (hold) step();
        end
        repeat (6) step();
    endtask

    task automatic set_gate0(input logic [1:0] v, input int hold);
        {outer[0], inner[0]} = v;
        repeat (hold) step();
    endtask

    task automatic check_drained(input string name);
        n_chk++;
        if (sb.size() != 0 || pend) begin
            n_fail++;
            $display("FAIL %s_drained: got %0d pending pulses want 0", name, sb.size());
            sb.delete();
            pend = 0;
        end
    endtask

    task automatic check_count(input string name, input int c);
        n_chk++;
        if (count !== CW'(c) || full !== (c == CAP) || empty !== (c == 0)) begin
            n_fail++;
            $display("FAIL %s: got count=%0d full=%b empty=%b want count=%0d", name, count, full, empty, c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; outer = '0; inner = '0;
        repeat (2) step();
        check_count("reset_count", 0);
        n_chk++;
        if (enter !== '0 || exit !== '0 || reject !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got enter=%b exit=%b reject=%b want 0", enter, exit, reject);
        end
        n_chk++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== exp_hex(0)) begin
            n_fail++;
            $display("FAIL reset_hex: got %h want %h", {hex5, hex4, hex3, hex2, hex1, hex0}, exp_hex(0));
        end
        reset = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_enter();
        push_exp(2'b01, 2'b00);
        set_gate0(2'b10, 5);
        set_gate0(2'b11, 5);
        set_gate0(2'b01, 5);
        set_gate0(2'b00, 3);
        n_chk++;
        if (enter !== 2'b00) begin
            n_fail++;
            $display("FAIL enter_latency_early: got enter=%b want 00", enter);
        end
        step();
        n_chk++;
        if (enter !== 2'b01) begin
            n_fail++;
            $display("FAIL enter_latency: got enter=%b want 01", enter);
        end
        step();
        n_chk++;
        if (enter !== 2'b00) begin
            n_fail++;
            $display("FAIL enter_single_pulse: got enter=%b want 00", enter);
        end
        check_count("enter_count", 1);
        repeat (3) step();
        check_drained("enter");
    endtask

    task automatic test_exit();
        gate_seq(2'b01, 2'b00, 2);
        gate_seq(2'b10, 2'b00, 2);
        check_count("exit_pre", 3);
        gate_seq(2'b00, 2'b10, 2);
        check_count("exit_one", 2);
        gate_seq(2'b00, 2'b10, 2);
        gate_seq(2'b00, 2'b01, 2);
        check_count("exit_to_zero", 0);
        gate_seq(2'b00, 2'b10, 2);
        check_count("exit_at_zero", 0);
        check_drained("exit");
    endtask

    task automatic test_abort();
        set_gate0(2'b10, 3);
        set_gate0(2'b11, 3);
        set_gate0(2'b10, 3);
        set_gate0(2'b00, 6);
        set_gate0(2'b11, 3);
        set_gate0(2'b00, 6);
        set_gate0(2'b10, 3);
        set_gate0(2'b01, 3);
        set_gate0(2'b00, 8);
        check_count("abort_count", 0);
        check_drained("abort");
    endtask

    task automatic test_full();
        for (int i = 0; i < CAP - 1; i++)
            gate_seq((i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 2);
        check_count("fill_15", CAP - 1);
        gate_seq(2'b11, 2'b00, 2);
        check_count("saturate_full", CAP);
        gate_seq(2'b01, 2'b10, 2);
        check_count("cancel_at_full", CAP);
        gate_seq(2'b00, 2'b01, 2);
        check_count("leave_full", CAP - 1);
        check_drained("full");
    endtask

    task automatic test_reset_mid();
        set_gate0(2'b10, 3);
        set_gate0(2'b11, 3);
        reset = 1'b0;
        repeat (2) step();
        model_count = 0;
        reset = 1'b1;
        set_gate0(2'b01, 3);
        set_gate0(2'b00, 8);
        check_count("reset_mid_count", 0);
        n_chk++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== exp_hex(0)) begin
            n_fail++;
            $display("FAIL reset_mid_hex: got %h want %h", {hex5, hex4, hex3, hex2, hex1, hex0}, exp_hex(0));
        end
        check_drained("reset_mid");
    endtask

    initial begin
        n_chk = 0; n_fail = 0; pend = 0; model_count = 0;
        reset = 1'b0; outer = '0; inner = '0;
        test_reset();
        test_enter();
        test_exit();
        test_abort();
        test_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/parking_lot_monitor.md
PARKING_LOT_MONITOR -- requirements
Module: parking_lot_monitor

Interface
REQ-001 Parameter NUM_GATES, default 2, number of independent entrance/exit gates (legal range 1..4).
REQ-002 Parameter CAPACITY, default 16, maximum occupancy (legal range 1..99).
REQ-003 Parameter CNT_W, default $clog2(CAPACITY+1), width of count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-006 outer  input  NUM_GATES  raw outer sensor per gate, 1 = blocked, asynchronous to clk.
REQ-007 inner  input  NUM_GATES  raw inner sensor per gate, 1 = blocked, asynchronous to clk.
REQ-008 enter  output  NUM_GATES  one-cycle pulse per gate on completed entry.
REQ-009 exit  output  NUM_GATES  one-cycle pulse per gate on completed exit.
REQ-010 count  output  CNT_W  current occupancy.
REQ-011 full  output  1  high when count == CAPACITY.
REQ-012 empty  output  1  high when count == 0.
REQ-013 reject  output  1  one-cycle pulse when an entry is dropped by saturation.
REQ-014 HEX0..HEX5  output  7 each  active-low seven-segment drives.

Function
REQ-015 Each outer/inner bit SHALL pass through a 2-flop synchronizer before use.
REQ-016 Each gate SHALL run its own FSM on synchronized {outer,inner}: IDLE, IN1(10), IN2(11), IN3(01), OUT1(01), OUT2(11), OUT3(10), WAIT.
REQ-017 Transitions: IDLE-10->IN1, IDLE-01->OUT1; IN1-11->IN2; IN2-01->IN3; OUT1-11->OUT2; OUT2-10->OUT3; otherwise hold on unchanged input.
REQ-018 Backtrack one step (e.g. IN2-10->IN1, IN3-11->IN2) SHALL be legal; 00 from IN1/IN2/OUT1/OUT2 SHALL return to IDLE with no pulse.
REQ-019 IN3-00->IDLE SHALL register enter[g]; OUT3-00->IDLE SHALL register exit[g]; pulse high exactly one cycle.
REQ-020 Any other pattern (e.g. IDLE-11, IN1-01) SHALL go to WAIT; WAIT-00->IDLE, no pulse.
REQ-021 Latency: enter/exit pulse asserted on 4th rising edge after the raw 00 is first present at the inputs (2 sync + FSM + pulse register).
REQ-022 Counter SHALL apply net delta = popcount(enter) - popcount(exit) in a single update; count valid the cycle after the pulses.
REQ-023 Result SHALL saturate to [0, CAPACITY]; exits at 0 are ignored silently.
REQ-024 If count + delta > CAPACITY, count SHALL become CAPACITY and reject SHALL pulse the same cycle count updates.
REQ-025 Simultaneous enter on one gate and exit on another SHALL cancel, count unchanged, no reject, even when full.
REQ-026 full and empty SHALL be registered, consistent with count in the same cycle.
REQ-027 Display: count==0 -> HEX5..HEX0 = "CLEAR0"; count==CAPACITY -> HEX5..HEX2 = "FULL", HEX1..HEX0 = decimal count; else HEX1..HEX0 = decimal count, tens blanked when zero, HEX5..HEX2 blank.

Reset
REQ-028 While reset==0 at a rising edge: all FSMs -> IDLE, synchronizers -> 0, count=0, empty=1, full=0, enter=exit=0, reject=0.
REQ-029 Reset mid-sequence SHALL discard the partial sequence; no pulse generated after release until a fresh full sequence.
REQ-030 Display SHALL show "CLEAR0" the cycle after reset.

Configuration
REQ-031 Macro PARKING_LOT_MONITOR_HEX_EN defined: HEX decode per REQ-027 compiled in.
REQ-032 Macro undefined: decode logic absent, HEX0..HEX5 SHALL be constant 7'b1111111; all other behaviour identical.

Verification
REQ-033 Gate0 sequence 00,10,11,01,00 (each held 5 cycles) -> enter[0] single pulse, count 0->1, empty falls, HEX0 "1".
REQ-034 Gate1 sequence 00,01,11,10,00 from count 3 -> exit[1] single pulse, count 2; same sequence at count 0 -> exit[1] pulses, count stays 0.
REQ-035 Gate0 10,11,10,00 (backtrack/abort) and 00->11 glitch -> no pulses, count unchanged.
REQ-036 CAPACITY=16, count 15, entries complete on gates 0 and 1 same cycle -> count 16, full=1, reject pulse, HEX "FULL16".
REQ-037 count 16, gate0 entry and gate1 exit same cycle -> count 16, no reject.
REQ-038 Reset asserted while gate0 in IN2, released, sensors go 01,00 -> no enter pulse, count 0, "CLEAR0".
